// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-legality check for the load/store sequencer.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access is rejected before touching memory: unknown width, unsigned store, or misalignment.
  function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic bad_f3;
    logic bad_st;
    logic bad_h;
    logic bad_w;
    bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    bad_st = we && funct3[2];
    bad_h  = ((funct3 == F3_H) || (funct3 == F3_HU)) && off[0];
    bad_w  = (funct3 == F3_W) && (off != 2'b00);
    return bad_f3 || bad_st || bad_h || bad_w;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load lane extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_lanes,
  output logic [XLEN-1:0] rdata_ext
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    case (funct3[1:0])
      2'b00: begin
        be          = BE_W'(4'b0001 << off);
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be          = BE_W'(4'b0011 << {off[1], 1'b0});
        wdata_lanes = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Addressed byte/halfword moved down to bit 0 before extension.
  always_comb begin
    shifted   = rdata >> {off, 3'b000};
    rdata_ext = shifted;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
      F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one access, runs the memory req/gnt/rvalid handshake,
// returns extended load data or an error, and stalls the pipeline while busy.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  lsu_state_e      state;
  lsu_state_e      state_d;
  logic            accept;
  logic            capture;
  logic            err_c;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [2:0]      funct3_sel;
  logic [1:0]      off_sel;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] wdata_lanes;
  logic [XLEN-1:0] rdata_ext;

  // Lane logic sees the live request while idle and the latched request afterwards.
  assign funct3_sel = (state == ST_IDLE) ? req_funct3_i : funct3_q;
  assign off_sel    = (state == ST_IDLE) ? req_addr_i[1:0] : off_q;
  assign err_c      = access_err(req_we_i, req_funct3_i, req_addr_i[1:0]);

  lsu_align u_align (
    .funct3      (funct3_sel),
    .off         (off_sel),
    .wdata       (req_wdata_i),
    .rdata       (mem_rdata_i),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    req_ready_o = 1'b0;
    stall_o     = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        stall_o     = req_valid_i;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = err_c ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        stall_o = 1'b1;
        if (mem_gnt_i) state_d = we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and registered memory/response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        off_q    <= req_addr_i[1:0];
      end
      mem_req_o <= (state_d == ST_ISSUE);
      if (accept && !err_c) begin
        mem_we_o    <= req_we_i;
        mem_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
        mem_be_o    <= be;
        mem_wdata_o <= req_we_i ? wdata_lanes : '0;
      end else if ((state == ST_ISSUE) && mem_gnt_i) begin
        mem_we_o    <= 1'b0;
        mem_addr_o  <= '0;
        mem_be_o    <= '0;
        mem_wdata_o <= '0;
      end
      rsp_valid_o <= (state_d == ST_RESP);
      rsp_err_o   <= accept && err_c;
      rsp_rdata_o <= capture ? rdata_ext : '0;
    end
  end

endmodule
